// File: rtl/pll_profile_ctrl_if.sv
// Avalon-MM reconfiguration management bus between the profile controller and the PLL reconfig block.
// Latency: n/a (signal bundle only).
// Backpressure: slave holds mgmt_waitrequest high to stall; master keeps strobes, address and data stable meanwhile.
interface pll_profile_ctrl_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_read;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
        output mgmt_readdata, mgmt_waitrequest
    );
endinterface

// File: rtl/pll_profile_ctrl.sv
// PLL profile switcher: rewrites M/K/C counters over the reconfig bus, starts reconfig, waits for relock.
// Latency: (4+NUM_CLK)*2 cycles to START completion plus lock time; same-profile request -> done 2 cycles after req.
// Backpressure: each bus transaction holds until mgmt_waitrequest=0; PLL_PROFILE_READBACK_EN adds an M readback check.
module pll_profile_ctrl #(
    parameter int                                 NUM_PROFILES    = 2,
    parameter int                                 NUM_CLK         = 3,
    parameter logic [NUM_PROFILES*18-1:0]         PROF_M          = {18'h00504, 18'h00504},
    parameter logic [NUM_PROFILES*32-1:0]         PROF_K          = {32'hA020_0000, 32'hA020_0000},
    parameter logic [NUM_PROFILES*NUM_CLK*18-1:0] PROF_C          = {(NUM_PROFILES*NUM_CLK){18'h00302}},
    parameter int                                 DEFAULT_PROFILE = 0,
    parameter int                                 LOCK_TIMEOUT    = 65535
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [2:0]         sel,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         cur_profile,
    input  logic               pll_locked,
    pll_profile_ctrl_if.master mgmt
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_MODE      = 4'd1;
    localparam logic [3:0] S_WR_M      = 4'd2;
    localparam logic [3:0] S_WR_K      = 4'd3;
    localparam logic [3:0] S_WR_C      = 4'd4;
    localparam logic [3:0] S_START     = 4'd5;
    localparam logic [3:0] S_WAIT_LOCK = 4'd6;
`ifdef PLL_PROFILE_READBACK_EN
    localparam logic [3:0] S_RB_M      = 4'd7;
    localparam logic [3:0] S_RB_CMP    = 4'd8;
`endif
    localparam logic [3:0] S_DONE      = 4'd9;
    localparam logic [3:0] S_ERR       = 4'd10;

    localparam logic [3:0]  NP       = 4'(NUM_PROFILES);
    localparam logic [1:0]  LAST_CLK = 2'(NUM_CLK - 1);
    localparam logic [15:0] TIMEOUT  = 16'(LOCK_TIMEOUT);
    localparam logic [2:0]  DEF_PROF = 3'(DEFAULT_PROFILE);

    logic [3:0]  state;
    logic [2:0]  sel_q;
    logic [1:0]  clk_idx;
    logic [15:0] lock_cnt;
    logic        seen_low;
    logic        lock_s1, lock_sync;
    logic        wr_q;
    logic [5:0]  addr_q;
    logic [31:0] wdat_q;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        unused_rd;

    assign unused_rd = ^mgmt.mgmt_readdata;

    assign mgmt.mgmt_write     = wr_q;
    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = wdat_q;

`ifdef PLL_PROFILE_READBACK_EN
    logic        rd_q;
    logic [17:0] rb_dat;
    assign mgmt.mgmt_read = rd_q;
`else
    assign mgmt.mgmt_read = 1'b0;
`endif

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_s1   <= pll_locked;
            lock_sync <= lock_s1;
        end
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (state)
            S_MODE:  begin wr_addr = 6'd0; wr_data = 32'd1; end
            S_WR_M:  begin wr_addr = 6'd4; wr_data = {14'b0, PROF_M[int'(sel_q)*18 +: 18]}; end
            S_WR_K:  begin wr_addr = 6'd7; wr_data = PROF_K[int'(sel_q)*32 +: 32]; end
            S_WR_C:  begin
                wr_addr = 6'd5;
                wr_data = {9'b0, 3'b0, clk_idx,
                           PROF_C[(int'(sel_q)*NUM_CLK + int'(clk_idx))*18 +: 18]};
            end
            S_START: begin wr_addr = 6'd2; wr_data = 32'd1; end
            default: ;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sel_q       <= DEF_PROF;
            clk_idx     <= '0;
            lock_cnt    <= '0;
            seen_low    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cur_profile <= DEF_PROF;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdat_q      <= '0;
`ifdef PLL_PROFILE_READBACK_EN
            rd_q        <= 1'b0;
            rb_dat      <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    if ({1'b0, sel} >= NP) begin
                        state <= S_ERR;
                    end else if (sel == cur_profile) begin
                        sel_q <= sel;
                        state <= S_DONE;
                    end else begin
                        sel_q   <= sel;
                        busy    <= 1'b1;
                        clk_idx <= '0;
                        state   <= S_MODE;
                    end
                end
                // Strobe rises on the first cycle in a state, so every transaction is preceded by an idle cycle.
                S_MODE, S_WR_M, S_WR_K, S_WR_C, S_START: begin
                    if (!wr_q) begin
                        wr_q   <= 1'b1;
                        addr_q <= wr_addr;
                        wdat_q <= wr_data;
                    end else if (!mgmt.mgmt_waitrequest) begin
                        wr_q <= 1'b0;
                        case (state)
                            S_MODE: state <= S_WR_M;
                            S_WR_M: state <= S_WR_K;
                            S_WR_K: state <= S_WR_C;
                            S_WR_C: begin
                                if (clk_idx == LAST_CLK) state <= S_START;
                                else                     clk_idx <= clk_idx + 2'd1;
                            end
                            S_START: begin
`ifdef PLL_PROFILE_READBACK_EN
                                state    <= S_RB_M;
`else
                                lock_cnt <= '0;
                                seen_low <= 1'b0;
                                state    <= S_WAIT_LOCK;
`endif
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
`ifdef PLL_PROFILE_READBACK_EN
                S_RB_M: begin
                    if (!rd_q) begin
                        rd_q   <= 1'b1;
                        addr_q <= 6'd4;
                    end else if (!mgmt.mgmt_waitrequest) begin
                        rd_q   <= 1'b0;
                        rb_dat <= mgmt.mgmt_readdata[17:0];
                        state  <= S_RB_CMP;
                    end
                end
                S_RB_CMP: begin
                    if (rb_dat != PROF_M[int'(sel_q)*18 +: 18]) begin
                        state <= S_ERR;
                    end else begin
                        lock_cnt <= '0;
                        seen_low <= 1'b0;
                        state    <= S_WAIT_LOCK;
                    end
                end
`endif
                // A stale lock from before the reconfig must not count: require a low sample first.
                S_WAIT_LOCK: begin
                    if (!lock_sync) seen_low <= 1'b1;
                    if (seen_low && lock_sync)     state    <= S_DONE;
                    else if (lock_cnt == TIMEOUT)  state    <= S_ERR;
                    else                           lock_cnt <= lock_cnt + 16'd1;
                end
                S_DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    cur_profile <= sel_q;
                    state       <= S_IDLE;
                end
                S_ERR: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_profile_ctrl.sv
// Directed bench for pll_profile_ctrl: profile switch, no-op/bad requests, stall, lock timeout, reset abort.
module tb_pll_profile_ctrl;
    localparam logic [35:0]  P_M = {18'h00A0C, 18'h00504};
    localparam logic [63:0]  P_K = {32'hB030_0000, 32'hA020_0000};
    localparam logic [107:0] P_C = {18'h00606, 18'h00505, 18'h00404, 18'h00302, 18'h00302, 18'h00302};

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       req, busy, done, err, pll_locked;
    logic [2:0] sel, cur_profile;
    logic       req_b, busy_b, done_b, err_b, lock_b;
    logic [2:0] sel_b, cur_b;

    pll_profile_ctrl_if bus ();
    pll_profile_ctrl_if bus_b ();

    pll_profile_ctrl #(
        .NUM_PROFILES(2), .NUM_CLK(3), .PROF_M(P_M), .PROF_K(P_K), .PROF_C(P_C),
        .DEFAULT_PROFILE(0), .LOCK_TIMEOUT(65535)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .req(req), .sel(sel), .busy(busy), .done(done),
        .err(err), .cur_profile(cur_profile), .pll_locked(pll_locked), .mgmt(bus.master)
    );

    pll_profile_ctrl #(.LOCK_TIMEOUT(100)) dut_b (
        .refclk(refclk), .rst_n(rst_n), .req(req_b), .sel(sel_b), .busy(busy_b), .done(done_b),
        .err(err_b), .cur_profile(cur_b), .pll_locked(lock_b), .mgmt(bus_b.master)
    );

    always #5 refclk = ~refclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor on the falling edge: logs writes that complete on the next rising edge.
    int          wr_cnt = 0, rd_cnt = 0, gap_viol = 0, done_cnt = 0, err_cnt = 0;
    logic        ack_prev = 1'b0;
    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge refclk) begin
        if (bus.mgmt_read) rd_cnt++;
        if (ack_prev && (bus.mgmt_write || bus.mgmt_read)) gap_viol++;
        if (bus.mgmt_write && bus.mgmt_read) gap_viol++;
        ack_prev = bus.mgmt_write && !bus.mgmt_waitrequest;
        if (ack_prev) begin
            wr_cnt++;
            wa_q.push_back(bus.mgmt_address);
            wd_q.push_back(bus.mgmt_writedata);
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic smp;
        @(negedge refclk);
        #1;
    endtask

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] s);
        tick();
        req = 1'b1;
        sel = s;
        tick();
        req = 1'b0;
    endtask

    logic [5:0]  exp_a [7] = '{6'd0, 6'd4, 6'd7, 6'd5, 6'd5, 6'd5, 6'd2};
    logic [31:0] exp_d [7] = '{32'd1, 32'h00A0C, 32'hB030_0000, 32'h00404, 32'h40505, 32'h80606, 32'd1};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, e0, n, hits;
        bit found;
        rst_n = 1'b0; req = 1'b0; sel = 3'd0; pll_locked = 1'b1;
        req_b = 1'b0; sel_b = 3'd0; lock_b = 1'b0;
        bus.mgmt_waitrequest = 1'b0; bus.mgmt_readdata = 32'h0;
        bus_b.mgmt_waitrequest = 1'b0; bus_b.mgmt_readdata = 32'h0;
        repeat (3) tick();
        smp();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst write", bus.mgmt_write, 0);
        chk("rst addr", bus.mgmt_address, 0);
        chk("rst wdata", bus.mgmt_writedata, 0);
        chk("rst cur", cur_profile, 0);
        tick(); rst_n = 1'b1;
        repeat (3) tick();

        // Same profile: done two cycles after req, no bus traffic.
        base = wr_cnt;
        pulse_req(3'd0);
        smp(); chk("same done early", done, 0); chk("same busy", busy, 0);
        smp(); chk("same done", done, 1);
        smp(); chk("same done 1cyc", done, 0);
        repeat (4) smp();
        chk("same writes", wr_cnt - base, 0);
        chk("same cur", cur_profile, 0);

        // Out-of-range profile: err pulse, nothing else moves.
        base = wr_cnt;
        pulse_req(3'd5);
        smp(); chk("bad busy", busy, 0); chk("bad err early", err, 0);
        smp(); chk("bad err", err, 1);
        repeat (4) smp();
        chk("bad writes", wr_cnt - base, 0);
        chk("bad cur", cur_profile, 0);

        // Switch to profile 1, lock returns 200 cycles later.
        wa_q.delete(); wd_q.delete();
        base = wr_cnt; d0 = done_cnt;
        tick(); req = 1'b1; sel = 3'd1; pll_locked = 1'b0;
        tick(); req = 1'b0;
        repeat (199) tick();
        chk("sw busy wait", busy, 1);
        chk("sw early done", done_cnt - d0, 0);
        pll_locked = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin smp(); if (done) found = 1; end
        chk("sw done seen", found, 1);
        smp();
        chk("sw cur", cur_profile, 1);
        chk("sw busy end", busy, 0);
        chk("sw nwrites", wr_cnt - base, 7);
        for (int i = 0; i < 7 && i < wa_q.size(); i++) begin
            chk($sformatf("sw addr%0d", i), wa_q[i], exp_a[i]);
            chk($sformatf("sw data%0d", i), wd_q[i], exp_d[i]);
        end

        // Back to profile 0 with a long stall on the K write and an ignored second req.
        wa_q.delete(); wd_q.delete();
        base = wr_cnt;
        tick(); req = 1'b1; sel = 3'd0; pll_locked = 1'b0;
        tick(); req = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            smp(); if (bus.mgmt_write && bus.mgmt_address == 6'd4) found = 1;
        end
        chk("stall reach M", found, 1);
        tick(); bus.mgmt_waitrequest = 1'b1;
        smp();
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("stall write", bus.mgmt_write, 1);
            chk("stall addr", bus.mgmt_address, 7);
            chk("stall data", bus.mgmt_writedata, 32'hA020_0000);
            if (i == 3) begin req = 1'b1; sel = 3'd1; end
            if (i == 4) req = 1'b0;
        end
        tick(); bus.mgmt_waitrequest = 1'b0;
        repeat (40) tick();
        pll_locked = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin smp(); if (done) found = 1; end
        chk("stall done seen", found, 1);
        hits = 0;
        for (int i = 0; i < 20; i++) begin smp(); if (busy) hits++; end
        chk("ignored req busy", hits, 0);
        chk("stall cur", cur_profile, 0);
        chk("stall nwrites", wr_cnt - base, 7);
        if (wa_q.size() > 2) chk("stall K logged", wd_q[2], 32'hA020_0000);

        // Lock never returns: err after 14 write cycles + 101 WAIT_LOCK cycles + ERR + err flop.
        tick(); req_b = 1'b1; sel_b = 3'd1;
        tick(); req_b = 1'b0;
        n = 0; found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            smp();
            if (err_b) found = 1; else n++;
        end
        chk("to err seen", found, 1);
        chk("to cycles", n, 116);
        chk("to busy", busy_b, 0);
        chk("to cur", cur_b, 0);

        // Reset while C counters are being written.
        e0 = err_cnt;
        pulse_req(3'd1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            smp(); if (bus.mgmt_write && bus.mgmt_address == 6'd5) found = 1;
        end
        chk("rstmid reach C", found, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid write", bus.mgmt_write, 0);
        chk("rstmid busy", busy, 0);
        tick(); rst_n = 1'b1;
        base = wr_cnt;
        smp();
        chk("rstmid cur", cur_profile, 0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin smp(); if (busy) hits++; end
        chk("rstmid resume busy", hits, 0);
        chk("rstmid writes", wr_cnt - base, 0);
        chk("rstmid err", err_cnt - e0, 0);

        chk("bus gaps", gap_viol, 0);
        chk("bus reads", rd_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pll_profile_ctrl.md
PLL_PROFILE_CTRL -- requirements
Module: pll_profile_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROFILES, default 2, number of stored PLL profiles (2..8).
REQ-002 SHALL have parameter NUM_CLK, default 3, number of PLL C counters rewritten per profile (1..4).
REQ-003 SHALL have parameter PROF_M, default {18'h00504,18'h00504}, flattened M-counter word per profile, profile 0 in LSBs.
REQ-004 SHALL have parameter PROF_K, default {32'hA020_0000,32'hA020_0000}, flattened fractional-K word per profile.
REQ-005 SHALL have parameter PROF_C, default all 18'h00302, flattened C-counter words, index (profile*NUM_CLK+clk).
REQ-006 SHALL have parameter DEFAULT_PROFILE, default 0, profile assumed loaded after reset.
REQ-007 SHALL have parameter LOCK_TIMEOUT, default 65535, refclk cycles allowed for relock (16-bit counter).
REQ-008 refclk  input  1  management clock; all logic rising-edge.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 req  input  1  one-cycle profile-change request.
REQ-011 sel  input  3  requested profile index, sampled when req=1.
REQ-012 busy  output  1  high from accepted req until done/err.
REQ-013 done  output  1  one-cycle pulse: profile applied and PLL locked.
REQ-014 err  output  1  one-cycle pulse: bad sel, lock timeout or readback mismatch.
REQ-015 cur_profile  output  3  last successfully applied profile.
REQ-016 pll_locked  input  1  PLL lock, asynchronous; two-flop synchronised internally.
REQ-017 mgmt_address  output  6  reconfig register address.
REQ-018 mgmt_read / mgmt_write  output  1 each  Avalon-MM strobes.
REQ-019 mgmt_writedata  output  32  write data.
REQ-020 mgmt_readdata  input  32  read data.
REQ-021 mgmt_waitrequest  input  1  stall; strobes, address, data held stable while high.

Function
REQ-022 States SHALL be IDLE, MODE, WR_M, WR_K, WR_C, START, WAIT_LOCK, (RB_M, RB_CMP with macro), DONE, ERR.
REQ-023 IDLE+req: sel>=NUM_PROFILES -> ERR (no bus traffic); sel==cur_profile -> DONE (no bus traffic); else latch sel, busy=1, -> MODE next cycle.
REQ-024 req while busy=1 SHALL be ignored, no queuing.
REQ-025 Write sequence, each one transaction completing on first cycle with mgmt_waitrequest=0: MODE addr 0 data 1 (polling mode); WR_M addr 4 data PROF_M; WR_K addr 7 data PROF_K; WR_C addr 5 data {9'b0, clk[4:0] in [22:18], PROF_C[17:0]} for clk=0..NUM_CLK-1 in ascending order; START addr 2 data 1.
REQ-026 Consecutive transactions SHALL have at least one idle cycle (strobes low) between them; read and write never simultaneous.
REQ-027 WAIT_LOCK: 16-bit counter from 0; synchronised pll_locked=1 observed after a first-seen 0 -> DONE; counter reaching LOCK_TIMEOUT -> ERR.
REQ-028 DONE: done=1 one cycle, cur_profile<=latched sel, busy=0, -> IDLE.
REQ-029 ERR: err=1 one cycle, cur_profile unchanged, busy=0, -> IDLE.
REQ-030 Minimum latency for a real change with zero waitrequest: (4+NUM_CLK)*2 cycles to START completion plus lock time.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, busy/done/err/mgmt_read/mgmt_write=0, mgmt_address=0, mgmt_writedata=0, cur_profile=DEFAULT_PROFILE, counters 0, sync flops 0.
REQ-032 Reset mid-transaction SHALL abandon it; no resumption after release.

Configuration
REQ-033 With PLL_PROFILE_READBACK_EN defined: after START, RB_M issues read addr 4, RB_CMP compares mgmt_readdata[17:0] to PROF_M; mismatch -> ERR, match -> WAIT_LOCK.
REQ-034 Without PLL_PROFILE_READBACK_EN: RB states absent, START -> WAIT_LOCK directly, mgmt_read tied 0.

Verification
REQ-035 req, sel=1, waitrequest=0, lock drops then rises 200 cycles later -> writes 0/4/7/5/5/5/2 in order, done pulse, cur_profile=1.
REQ-036 req, sel=0 after reset -> done next-but-one cycle, zero mgmt_write pulses.
REQ-037 req, sel=5 (NUM_PROFILES=2) -> err pulse, no bus traffic, cur_profile unchanged.
REQ-038 waitrequest held high 10 cycles on WR_K -> address 7 and data stable throughout; second req during busy ignored.
REQ-039 LOCK_TIMEOUT=100, lock never rises -> err exactly at count 100, cur_profile unchanged.
REQ-040 rst_n low during WR_C -> mgmt_write=0 asynchronously; after release busy=0, cur_profile=DEFAULT_PROFILE.
